// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
//   Shared types and limits for the pipeline hazard controller.
//   hazard_state_e : controller FSM states
//   MAX_LOAD_STALL : largest supported load-use bubble count
//   REM_W          : width of the remaining-bubble counter
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } hazard_state_e;

    localparam int MAX_LOAD_STALL = 4;
    // Holds up to MAX_LOAD_STALL-1: the first bubble is the hit cycle itself.
    localparam int REM_W          = 2;

endpackage

// File: rtl/hazard_stall_ctrl_perf_sat_counter.sv
// perf_sat_counter
//   Saturating event counter. Counts rising-edge cycles with inc=1 and
//   holds at all-ones.
//   clk : clock
//   rst : async active-high reset, clears the count
//   inc : count this cycle
//   cnt : current count
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard controller for a 5-stage core: load-use stalls of
//   LOAD_STALL bubbles, taken-branch flushes of FLUSH_DEPTH registers,
//   freezes on imem/dmem wait states, saturating stall/flush counters.
//   Outputs are Mealy: they react in the same cycle as the hazard.
//   Inputs : idex_memread/idex_rd (EX load), ifid_rs1/rs2 + use flags (ID
//            sources), pcsrc (taken branch), imem_ready, dmem_ready.
//   Outputs: en_pc/en_ifid/en_idex/en_exmem/en_memwb register enables,
//            flush_ifid/flush_idex/flush_exmem NOP loads, busy (not RUN),
//            stall_cnt (cycles with en_pc=0), flush_cnt (branch flushes).
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             pcsrc,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_e    state, state_nxt;
    logic [REM_W-1:0] rem, rem_nxt;

    // Load-use comparator; x0 never carries a hazard.
    logic hit;
    assign hit = idex_memread && (idex_rd != '0) &&
                 ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                  (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    // A stall is in progress either in LSTALL or frozen inside MWAIT with
    // bubbles still owed (rem is held across the dmem wait).
    logic stall_active;
    assign stall_active = (state == LSTALL) || ((state == MWAIT) && (rem != '0));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Next state, priority: dmem wait > branch > active stall > new hit
    always_comb begin
        state_nxt = RUN;
        rem_nxt   = rem;
        if (!dmem_ready) begin
            state_nxt = MWAIT;
        end else if (pcsrc) begin
            state_nxt = RUN;
            rem_nxt   = '0;
        end else if (stall_active) begin
            if (rem <= REM_W'(1)) begin
                state_nxt = RUN;
                rem_nxt   = '0;
            end else begin
                state_nxt = LSTALL;
                rem_nxt   = rem - REM_W'(1);
            end
        end else if (hit && (LOAD_STALL > 1)) begin
            state_nxt = LSTALL;
            rem_nxt   = REM_W'(LOAD_STALL - 1);
        end else begin
            state_nxt = RUN;
            rem_nxt   = '0;
        end
    end

    // Output decode
    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (rst) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = '0;
            {flush_ifid, flush_idex, flush_exmem}         = '1;
        end else if (!dmem_ready) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = '0;
        end else if (pcsrc) begin
            flush_ifid  = 1'b1;
            flush_idex  = (FLUSH_DEPTH >= 2);
            flush_exmem = (FLUSH_DEPTH >= 3);
        end else if (stall_active || hit) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else if (!imem_ready) begin
            // Hold PC, feed a bubble into ID while the rest drains.
            en_pc      = 1'b0;
            flush_ifid = 1'b1;
        end
    end

    assign busy = !rst && (state != RUN);

    logic flush_inc;
    assign flush_inc = !rst && dmem_ready && pcsrc;

    perf_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!en_pc),
        .cnt (stall_cnt)
    );

    perf_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. Instance 0: LOAD_STALL=3, FLUSH_DEPTH=3.
// Instance 1: LOAD_STALL=1, FLUSH_DEPTH=2. Output vector order:
// {en_pc,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,flush_idex,flush_exmem,busy}
module tb_hazard_stall_ctrl;

    localparam logic [8:0] O_NORM = 9'b11111_000_0;
    localparam logic [8:0] O_RST  = 9'b00000_111_0;
    localparam logic [8:0] O_HIT  = 9'b00111_010_0;
    localparam logic [8:0] O_STL  = 9'b00111_010_1;
    localparam logic [8:0] O_DW0  = 9'b00000_000_0;
    localparam logic [8:0] O_DW1  = 9'b00000_000_1;
    localparam logic [8:0] O_FL3B = 9'b11111_111_1;
    localparam logic [8:0] O_FL2  = 9'b11111_110_0;
    localparam logic [8:0] O_IW   = 9'b01111_100_0;

    logic       clk = 1'b0;
    logic       rst;
    logic       memread [2];
    logic [4:0] rd      [2];
    logic [4:0] rs1     [2];
    logic [4:0] rs2     [2];
    logic       use1    [2];
    logic       use2    [2];
    logic       pcsrc   [2];
    logic       imem    [2];
    logic       dmem    [2];

    wire [1:0][8:0]  outs;
    wire [1:0][31:0] scnt;
    wire [1:0][31:0] fcnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hazard_stall_ctrl #(
            .REG_W       (5),
            .LOAD_STALL  (g == 0 ? 3 : 1),
            .FLUSH_DEPTH (g == 0 ? 3 : 2),
            .CNT_W       (32)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .idex_memread (memread[g]),
            .idex_rd      (rd[g]),
            .ifid_rs1     (rs1[g]),
            .ifid_rs2     (rs2[g]),
            .ifid_use_rs1 (use1[g]),
            .ifid_use_rs2 (use2[g]),
            .pcsrc        (pcsrc[g]),
            .imem_ready   (imem[g]),
            .dmem_ready   (dmem[g]),
            .en_pc        (outs[g][8]),
            .en_ifid      (outs[g][7]),
            .en_idex      (outs[g][6]),
            .en_exmem     (outs[g][5]),
            .en_memwb     (outs[g][4]),
            .flush_ifid   (outs[g][3]),
            .flush_idex   (outs[g][2]),
            .flush_exmem  (outs[g][1]),
            .busy         (outs[g][0]),
            .stall_cnt    (scnt[g]),
            .flush_cnt    (fcnt[g])
        );
    end

    task automatic drive(input int k, input logic mr, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic a1, input logic a2, input logic pc,
                         input logic im, input logic dm);
        memread[k] = mr; rd[k] = d; rs1[k] = s1; rs2[k] = s2;
        use1[k] = a1; use2[k] = a2; pcsrc[k] = pc; imem[k] = im; dmem[k] = dm;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // lw x5 in EX, add x?,x5,x7 in ID
    task automatic hit(input int k, input logic dm);
        drive(k, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, dm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(0); idle(1);
        tick(); #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (outs[k] !== O_RST) $display("FAIL reset_outs[%0d] got=%b exp=%b", k, outs[k], O_RST);
            else n_pass++;
            n_chk++;
            if (scnt[k] !== 32'd0 || fcnt[k] !== 32'd0)
                $display("FAIL reset_cnt[%0d] got=%0d/%0d exp=0/0", k, scnt[k], fcnt[k]);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (outs[0] !== O_NORM) $display("FAIL reset_release got=%b exp=%b", outs[0], O_NORM);
        else n_pass++;
        tick();
    endtask

    task automatic test_load1();
        hit(1, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_HIT) $display("FAIL load1_hit got=%b exp=%b", outs[1], O_HIT);
        else n_pass++;
        tick(); idle(1); #2;
        n_chk++;
        if (outs[1] !== O_NORM) $display("FAIL load1_after got=%b exp=%b", outs[1], O_NORM);
        else n_pass++;
        n_chk++;
        if (scnt[1] !== 32'd1) $display("FAIL load1_cnt got=%0d exp=1", scnt[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_no_hazard();
        drive(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_NORM) $display("FAIL nohaz_x0 got=%b exp=%b", outs[1], O_NORM);
        else n_pass++;
        tick();
        drive(1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_NORM) $display("FAIL nohaz_rs2_unused got=%b exp=%b", outs[1], O_NORM);
        else n_pass++;
        tick();
        drive(1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_NORM) $display("FAIL nohaz_not_load got=%b exp=%b", outs[1], O_NORM);
        else n_pass++;
        tick(); idle(1); #2;
        n_chk++;
        if (scnt[1] !== 32'd1) $display("FAIL nohaz_cnt got=%0d exp=1", scnt[1]);
        else n_pass++;
    endtask

    task automatic test_load3();
        logic [8:0] exp [4];
        exp = '{O_HIT, O_STL, O_STL, O_NORM};
        hit(0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #2;
            n_chk++;
            if (outs[0] !== exp[c]) $display("FAIL load3_c%0d got=%b exp=%b", c, outs[0], exp[c]);
            else n_pass++;
            tick(); idle(0);
        end
        #2;
        n_chk++;
        if (scnt[0] !== 32'd3) $display("FAIL load3_cnt got=%0d exp=3", scnt[0]);
        else n_pass++;
    endtask

    task automatic test_flush_in_stall();
        hit(0, 1'b1); tick();
        drive(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); #2;
        n_chk++;
        if (outs[0] !== O_FL3B) $display("FAIL flush_stall got=%b exp=%b", outs[0], O_FL3B);
        else n_pass++;
        tick(); idle(0); #2;
        n_chk++;
        if (outs[0] !== O_NORM) $display("FAIL flush_stall_run got=%b exp=%b", outs[0], O_NORM);
        else n_pass++;
        n_chk++;
        if (fcnt[0] !== 32'd1 || scnt[0] !== 32'd4)
            $display("FAIL flush_stall_cnt got=%0d/%0d exp=1/4", fcnt[0], scnt[0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush_vs_hit();
        drive(1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_FL2) $display("FAIL flush_hit got=%b exp=%b", outs[1], O_FL2);
        else n_pass++;
        tick(); idle(1); #2;
        n_chk++;
        if (outs[1] !== O_NORM) $display("FAIL flush_hit_after got=%b exp=%b", outs[1], O_NORM);
        else n_pass++;
        n_chk++;
        if (fcnt[1] !== 32'd1 || scnt[1] !== 32'd1)
            $display("FAIL flush_hit_cnt got=%0d/%0d exp=1/1", fcnt[1], scnt[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_imem_wait();
        drive(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_IW) $display("FAIL imem_wait got=%b exp=%b", outs[1], O_IW);
        else n_pass++;
        tick(); idle(1); #2;
        n_chk++;
        if (scnt[1] !== 32'd2) $display("FAIL imem_cnt got=%0d exp=2", scnt[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_dmem_in_stall();
        logic [8:0] exp [7];
        exp = '{O_DW1, O_DW1, O_DW1, O_DW1, O_STL, O_STL, O_NORM};
        hit(0, 1'b1); tick();
        for (int c = 0; c < 7; c++) begin
            drive(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, (c >= 4)); #2;
            n_chk++;
            if (outs[0] !== exp[c]) $display("FAIL dmem_stall_c%0d got=%b exp=%b", c, outs[0], exp[c]);
            else n_pass++;
            tick();
        end
        idle(0); #2;
        n_chk++;
        if (scnt[0] !== 32'd11) $display("FAIL dmem_stall_cnt got=%0d exp=11", scnt[0]);
        else n_pass++;
    endtask

    task automatic test_dmem_from_run();
        drive(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #2;
        n_chk++;
        if (outs[1] !== O_DW0) $display("FAIL dmem_run_c0 got=%b exp=%b", outs[1], O_DW0);
        else n_pass++;
        tick(); #2;
        n_chk++;
        if (outs[1] !== O_DW1) $display("FAIL dmem_run_c1 got=%b exp=%b", outs[1], O_DW1);
        else n_pass++;
        tick(); hit(1, 1'b1); #2;
        n_chk++;
        if (outs[1] !== O_STL) $display("FAIL dmem_exit_hit got=%b exp=%b", outs[1], O_STL);
        else n_pass++;
        tick(); idle(1); #2;
        n_chk++;
        if (outs[1] !== O_NORM) $display("FAIL dmem_exit_run got=%b exp=%b", outs[1], O_NORM);
        else n_pass++;
        n_chk++;
        if (scnt[1] !== 32'd5) $display("FAIL dmem_run_cnt got=%0d exp=5", scnt[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        hit(0, 1'b1); tick();
        idle(0); #1;
        n_chk++;
        if (outs[0] !== O_STL) $display("FAIL rstmid_pre got=%b exp=%b", outs[0], O_STL);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (outs[0] !== O_RST) $display("FAIL rstmid_outs got=%b exp=%b", outs[0], O_RST);
        else n_pass++;
        n_chk++;
        if (scnt[0] !== 32'd0 || fcnt[0] !== 32'd0 || scnt[1] !== 32'd0 || fcnt[1] !== 32'd0)
            $display("FAIL rstmid_cnt got=%0d/%0d/%0d/%0d exp=0", scnt[0], fcnt[0], scnt[1], fcnt[1]);
        else n_pass++;
        tick();
        rst = 1'b0; #2;
        n_chk++;
        if (outs[0] !== O_NORM) $display("FAIL rstmid_release got=%b exp=%b", outs[0], O_NORM);
        else n_pass++;
        tick(); #2;
        n_chk++;
        if (outs[0] !== O_NORM || scnt[0] !== 32'd0)
            $display("FAIL rstmid_run got=%b/%0d exp=%b/0", outs[0], scnt[0], O_NORM);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load1();
        test_no_hazard();
        test_load3();
        test_flush_in_stall();
        test_flush_vs_hit();
        test_imem_wait();
        test_dmem_in_stall();
        test_dmem_from_run();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
